// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX-core signal bundle for the shared UART transmitter arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters and TX core that surround it.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 grant_valid;
  logic [IdW-1:0]       grant_id;
  logic                 tx_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, tx_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, tx_err
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ byte streams.
// Optionally locks the grant across a packet, sequences the core with a
// start/done handshake and aborts a stuck transfer with a watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter bit          LOCK_EN     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input logic              pclk,
  input logic              prst,
  uart_tx_arbiter_if.slave arb_if
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_err_q, tx_err_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic                 lock_q, lock_d;

  logic                 lo_hit, hi_hit, arb_hit;
  logic [IdW-1:0]       lo_sel, hi_sel, arb_sel;
  logic [7:0]           arb_data, own_data;
  logic                 arb_last, own_valid, own_last;
  logic [IdW-1:0]       rr_next;
  logic [NUM_REQ-1:0]   arb_onehot, own_onehot;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest overall.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_sel = '0;
    hi_sel = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (arb_if.req_valid[j]) begin
        if (!lo_hit) begin
          lo_sel = IdW'(j);
          lo_hit = 1'b1;
        end
        if (!hi_hit && (IdW'(j) >= rr_ptr_q)) begin
          hi_sel = IdW'(j);
          hi_hit = 1'b1;
        end
      end
    end
    arb_hit = lo_hit;
    arb_sel = hi_hit ? hi_sel : lo_sel;
  end

  // Byte/last muxes for the arbitration winner and for the current owner.
  always_comb begin
    arb_data   = '0;
    arb_last   = 1'b0;
    own_data   = '0;
    own_last   = 1'b0;
    own_valid  = 1'b0;
    arb_onehot = '0;
    own_onehot = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (IdW'(j) == arb_sel) begin
        arb_data      = arb_if.req_data[8*j +: 8];
        arb_last      = arb_if.req_last[j];
        arb_onehot[j] = 1'b1;
      end
      if (IdW'(j) == grant_id_q) begin
        own_data      = arb_if.req_data[8*j +: 8];
        own_last      = arb_if.req_last[j];
        own_valid     = arb_if.req_valid[j];
        own_onehot[j] = 1'b1;
      end
    end
  end

  assign rr_next = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Next-state and registered-output decode for the launch/wait/hold sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    tx_err_d      = 1'b0;
    wd_d          = wd_q;
    lock_d        = lock_q;

    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          grant_id_d    = arb_sel;
          grant_valid_d = 1'b1;
          tx_data_d     = arb_data;
          lock_d        = LOCK_EN & ~arb_last;
          tx_start_d    = 1'b1;
          req_ready_d   = arb_onehot;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        // tx_done during the launch cycle belongs to no transfer of ours.
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // tx_done has priority over a coincident timeout.
        if (arb_if.tx_done) begin
          if (lock_q) begin
            wd_d    = '0;
            state_d = StHold;
          end else begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = rr_next;
            state_d       = StIdle;
          end
        end else if (wd_q == WdMax) begin
          tx_err_d      = 1'b1;
          lock_d        = 1'b0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StHold: begin
        // Only the owner may continue its packet; others wait for release.
        if (own_valid) begin
          tx_data_d   = own_data;
          lock_d      = LOCK_EN & ~own_last;
          tx_start_d  = 1'b1;
          req_ready_d = own_onehot;
          state_d     = StLaunch;
        end else if (wd_q == WdMax) begin
          tx_err_d      = 1'b1;
          lock_d        = 1'b0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = rr_next;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      tx_err_q      <= 1'b0;
      wd_q          <= '0;
      lock_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      tx_err_q      <= tx_err_d;
      wd_q          <= wd_d;
      lock_q        <= lock_d;
    end
  end

  assign arb_if.tx_start    = tx_start_q;
  assign arb_if.req_ready   = req_ready_q;
  assign arb_if.tx_data     = tx_data_q;
  assign arb_if.grant_valid = grant_valid_q;
  assign arb_if.grant_id    = grant_id_q;
  assign arb_if.tx_err      = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/TX-core models drive the
// interface, tests push expected launches and aborts, a monitor pops and checks.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  typedef struct packed {
    logic       is_err;
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] ready;
  } exp_t;

  logic pclk = 1'b0;
  logic prst;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) arb_if ();

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LOCK_EN    (1'b1),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk  (pclk),
    .prst  (prst),
    .arb_if(arb_if)
  );

  always #5 pclk = ~pclk;

  exp_t       exp_q[$];
  logic [8:0] rq[NUM_REQ][$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_delay = 20;
  int err_seen = 0;
  int starts_seen = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester queues and TX-core model; sole driver of the DUT inputs.
  initial begin
    int done_cnt;
    logic [8:0] e;
    done_cnt = -1;
    arb_if.req_valid = '0;
    arb_if.req_data  = '0;
    arb_if.req_last  = '0;
    arb_if.tx_done   = 1'b0;
    forever begin
      @(negedge pclk);
      for (int i = 0; i < NUM_REQ; i++)
        if (arb_if.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          e = rq[i][0];
          arb_if.req_valid[i]       = 1'b1;
          arb_if.req_data[8*i +: 8] = e[7:0];
          arb_if.req_last[i]        = e[8];
        end else begin
          arb_if.req_valid[i]       = 1'b0;
          arb_if.req_data[8*i +: 8] = 8'h00;
          arb_if.req_last[i]        = 1'b0;
        end
      end
      arb_if.tx_done = 1'b0;
      if (arb_if.tx_start) done_cnt = done_delay;
      else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) arb_if.tx_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each launch or abort and checks invariants.
  initial begin
    exp_t e;
    logic [7:0] prev_data;
    logic [3:0] prev_ready;
    int last_start_cyc;
    prev_data = '0;
    prev_ready = '0;
    last_start_cyc = 0;
    forever begin
      @(negedge pclk);
      if (prst) begin
        prev_data  = '0;
        prev_ready = '0;
      end else begin
        if (arb_if.req_ready != 0 || arb_if.tx_start) begin
          chk("ready_onehot_with_start", {30'b0, arb_if.tx_start, $onehot(arb_if.req_ready)}, 32'd3);
          chk("ready_single_pulse", 32'(prev_ready), 32'd0);
        end
        if (!arb_if.tx_start && arb_if.tx_data != prev_data)
          chk("tx_data_stable", 32'(arb_if.tx_data), 32'(prev_data));
        if (arb_if.tx_err) err_seen++;
        if (arb_if.tx_start) starts_seen++;
        if (arb_if.tx_start || arb_if.tx_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'b0, arb_if.tx_start, arb_if.tx_err}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_err", 32'(arb_if.tx_err), 32'(e.is_err));
            chk("grant_id", 32'(arb_if.grant_id), 32'(e.id));
            if (e.is_err) begin
              chk("err_timing", 32'(cyc - last_start_cyc), 32'd65);
              chk("err_grant_released", 32'(arb_if.grant_valid), 32'd0);
            end else begin
              last_start_cyc = cyc;
              chk("tx_data", 32'(arb_if.tx_data), 32'(e.data));
              chk("req_ready", 32'(arb_if.req_ready), 32'(e.ready));
              chk("grant_valid", 32'(arb_if.grant_valid), 32'd1);
            end
          end
        end
        prev_data  = arb_if.tx_data;
        prev_ready = arb_if.req_ready;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_req(input int r, input logic last, input logic [7:0] d);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_start(input int id, input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.id     = 2'(id);
    e.data   = d;
    e.ready  = 4'b0001 << id;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input int id);
    exp_t e;
    e.is_err = 1'b1;
    e.id     = 2'(id);
    e.data   = '0;
    e.ready  = '0;
    exp_q.push_back(e);
  endtask

  function automatic bit reqs_pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || reqs_pending() || arb_if.grant_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    prst = 1'b1;
    tick();
    prst = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_start"}, 32'(arb_if.tx_start), 32'd0);
    chk({tag, "_req_ready"}, 32'(arb_if.req_ready), 32'd0);
    chk({tag, "_tx_data"}, 32'(arb_if.tx_data), 32'd0);
    chk({tag, "_grant_valid"}, 32'(arb_if.grant_valid), 32'd0);
    chk({tag, "_grant_id"}, 32'(arb_if.grant_id), 32'd0);
    chk({tag, "_tx_err"}, 32'(arb_if.tx_err), 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    int s0;
    prst = 1'b1;
    repeat (3) tick();
    chk_outputs_zero("reset");
    prst = 1'b0;

    // Single byte from requester 0, then rr_ptr=1 favours requester 1 over 0.
    done_delay = 20;
    tick();
    push_req(0, 1'b1, 8'hC5);
    expect_start(0, 8'hC5);
    t0 = cyc;
    n = 0;
    while (!arb_if.tx_start && n < 10) begin
      @(negedge pclk);
      n++;
    end
    chk("t1_start_latency", 32'(cyc - t0), 32'd1);
    wait_idle("t1_idle", 100);
    chk("t1_grant_id_held", 32'(arb_if.grant_id), 32'd0);
    push_req(0, 1'b1, 8'h11);
    push_req(1, 1'b1, 8'h22);
    expect_start(1, 8'h22);
    expect_start(0, 8'h11);
    wait_idle("t1_rr_idle", 200);

    // All four continuously valid: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_req(i, 1'b1, 8'(8'h40 + i));
      push_req(i, 1'b1, 8'(8'h50 + i));
    end
    for (int i = 0; i < NUM_REQ; i++) expect_start(i, 8'(8'h40 + i));
    for (int i = 0; i < NUM_REQ; i++) expect_start(i, 8'(8'h50 + i));
    wait_idle("t2_rr_idle", 600);

    // Locked packet from requester 2 holds off requester 0 until the last byte.
    push_req(2, 1'b0, 8'h0D);
    push_req(2, 1'b0, 8'hE9);
    push_req(2, 1'b1, 8'hA1);
    expect_start(2, 8'h0D);
    expect_start(2, 8'hE9);
    expect_start(2, 8'hA1);
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t3_first_launch", 32'(n < 50), 32'd1);
    push_req(0, 1'b1, 8'h77);
    expect_start(0, 8'h77);
    wait_idle("t3_lock_idle", 400);

    // Hung core: abort after the watchdog, then the next requester is served.
    done_delay = -1;
    push_req(1, 1'b1, 8'h3C);
    expect_start(1, 8'h3C);
    expect_err(1);
    wait_idle("t4_timeout_idle", 200);
    done_delay = 20;
    push_req(3, 1'b1, 8'hD2);
    expect_start(3, 8'hD2);
    wait_idle("t4_after_idle", 100);

    // Reset during WAIT: outputs clear, late tx_done ignored, rr_ptr back to 0.
    done_delay = 5;
    push_req(2, 1'b1, 8'h5A);
    expect_start(2, 8'h5A);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_launch_seen", 32'(n < 20), 32'd1);
    prst = 1'b1;
    tick();
    chk_outputs_zero("t5_rst");
    prst = 1'b0;
    s0 = starts_seen;
    repeat (12) tick();
    chk("t5_no_late_start", 32'(starts_seen - s0), 32'd0);
    push_req(3, 1'b1, 8'h33);
    push_req(1, 1'b1, 8'h11);
    expect_start(1, 8'h11);
    expect_start(3, 8'h33);
    wait_idle("t5_rr_idle", 100);

    // tx_done on the very cycle the watchdog expires: completes without error.
    done_delay = 64;
    push_req(0, 1'b1, 8'h99);
    expect_start(0, 8'h99);
    wait_idle("t6_coincide_idle", 200);

    chk("final_err_count", 32'(err_seen), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core between NUM_REQ byte-stream requesters. Typical requesters are the APB register path, a loopback/echo path and debug sources.
- Arbitrates round-robin and optionally locks the grant for a whole packet. Sequences the TX core with a start/done handshake.
- Guards each transfer with a watchdog so a hung core or stalled requester cannot deadlock the link.
- Sits between the requesters and the UART TX engine inside the APB UART subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_EN, 1, 1 = grant held until the requester's byte flagged req_last completes; 0 = re-arbitrate after every byte.
- TIMEOUT_CYC, 2048, pclk cycles allowed in WAIT or HOLD before abort (must exceed one frame time).

Ports:
- pclk  in  1  system clock, all logic on rising edge
- prst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is last of packet (used only when LOCK_EN=1)
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- tx_start  out  1  one-cycle launch pulse to the TX core
- tx_data  out  8  byte to transmit, registered
- tx_done  in  1  one-cycle pulse from the TX core when the stop bit has been sent
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  $clog2(NUM_REQ)  index of the owner
- tx_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: synchronous. When prst is sampled high, on that edge: state=IDLE, rr_ptr=0, and tx_start, req_ready, tx_data, grant_valid, grant_id, tx_err, watchdog and lock flag all go to 0. This applies mid-transfer too; no tx_start is issued after reset, and a tx_done arriving later is ignored.
- Requester handshake: req_data and req_last must hold while req_valid=1 until req_ready. A transfer occurs in the cycle where req_valid & req_ready.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - If any req_valid, select the first requester with valid set, searching from rr_ptr upward with wrap.
  - Next edge: grant_id=sel, grant_valid=1, tx_data=req_data[sel], lock = LOCK_EN & ~req_last[sel], state=LAUNCH.
  - If no req_valid, stay in IDLE.
- LAUNCH (exactly 1 cycle): tx_start=1, req_ready[grant_id]=1, watchdog cleared. Next state is WAIT. tx_done seen in this cycle is ignored.
- WAIT: watchdog increments every cycle.
  - On tx_done=1:
    - If lock=1, go to HOLD and clear the watchdog.
    - Otherwise go to IDLE with grant_valid=0 and rr_ptr = grant_id+1 mod NUM_REQ.
  - If the watchdog reaches TIMEOUT_CYC-1 without tx_done: tx_err=1 for one cycle, lock=0, grant released, rr_ptr advances as above, state=IDLE.
  - tx_done and timeout in the same cycle: tx_done wins, no error.
- HOLD (locked packet, same owner):
  - On req_valid[grant_id]: next edge loads tx_data, sets lock=~req_last[grant_id], state=LAUNCH. No re-arbitration.
  - Other requesters' valids are ignored.
  - The watchdog runs; on timeout, tx_err pulses, the grant is released to IDLE and rr_ptr advances.
- Latency: req_valid high on edge k (IDLE) gives tx_start high in cycle k+1. Back-to-back locked bytes: tx_done on edge k plus valid already high gives tx_start in cycle k+2.
- tx_start and req_ready are never high outside LAUNCH. At most one req_ready bit is high at a time.
- tx_data changes only on entry to LAUNCH and is stable through WAIT.
- grant_id holds its value after release; it is valid only when grant_valid=1.
- Watchdog width: $clog2(TIMEOUT_CYC). It saturates and does not wrap.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'hC5, last=1 → tx_start one cycle later with tx_data=8'hC5 and req_ready=4'b0001 in the same cycle. After tx_done: grant_valid=0, rr_ptr=1.
- All four requesters valid continuously, last=1, with tx_done returned 20 cycles after each start → grant order 0,1,2,3,0; every req_ready is a single-cycle pulse.
- LOCK_EN=1: requester 2 sends 8'h0D, 8'hE9, 8'hA1 (last on 8'hA1) while requester 0 is valid → all three bytes go to requester 2 first, then requester 0 is granted.
- No tx_done after tx_start with TIMEOUT_CYC=64 → tx_err pulses once, 64 cycles after entering WAIT; the grant is released; the next requester is served normally.
- prst asserted for one cycle during WAIT with a pending tx_done 3 cycles later → all outputs 0 after the edge, state IDLE, the late tx_done causes no tx_start, and rr_ptr=0.
- tx_done and the timeout coinciding in the same cycle → no tx_err, normal completion.
